// File: rtl/regfile_seq_pkg.sv
// Shared definitions for the register-file block-load sequencer.
//   state_t      : FSM state encoding (legacy-compatible localparam constants)
//   DefAddrStep  : default byte increment between consecutive words
//   RegPc        : register index that maps onto the PC write port
package regfile_seq_pkg;

  typedef logic [2:0] state_t;

  localparam state_t StIdle = 3'd0;
  localparam state_t StReq  = 3'd1;
  localparam state_t StWait = 3'd2;
  localparam state_t StWb   = 3'd3;
  localparam state_t StDone = 3'd4;

  localparam int unsigned DefAddrStep = 4;

  localparam logic [3:0] RegPc = 4'd15;

endpackage

// File: rtl/prio_enc16.sv
// Combinational lowest-set-bit encoder for a 16-bit vector.
//   vec   : input vector
//   idx   : index of the lowest set bit (0 when vec is empty)
//   valid : at least one bit of vec is set
module prio_enc16 (
  input  logic [15:0] vec,
  output logic [3:0]  idx,
  output logic        valid
);

  always_comb begin
    idx = '0;
    // Scan downwards so the lowest set bit is the last (winning) assignment.
    for (int i = 15; i >= 0; i--) begin
      if (vec[i]) begin
        idx = 4'(i);
      end
    end
    valid = |vec;
  end

endmodule

// File: rtl/regfile_ldm_sequencer.sv
// Block-load (LDM-style) write-side sequencer for the register file.
// Issues one memory read per register in reg_list, lowest index first at ascending addresses,
// and steers each returned word to the register file write port (WE3/A3/WD3) or, for R15,
// to the PC port. Optionally writes the final address back to the base register rn.
//   clk, rst                     : clock, asynchronous active-low reset
//   start, reg_list, base_addr,
//   wback, rn                    : command, captured when accepted in IDLE
//   mem_re, mem_addr             : single-cycle read request per word
//   mem_rdata, mem_rvalid        : read response, consumed only while waiting
//   WE3, A3, WD3                 : register file write port (R0..R14)
//   pc_we, pc_wdata              : PC write port
//   busy, done                   : activity flag and one-cycle completion pulse
module regfile_ldm_sequencer
  import regfile_seq_pkg::*;
#(
  parameter int unsigned N         = 32,
  parameter int unsigned ADDR_STEP = DefAddrStep
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [15:0]  reg_list,
  input  logic [N-1:0] base_addr,
  input  logic         wback,
  input  logic [3:0]   rn,
  output logic         mem_re,
  output logic [N-1:0] mem_addr,
  input  logic [N-1:0] mem_rdata,
  input  logic         mem_rvalid,
  output logic         WE3,
  output logic [3:0]   A3,
  output logic [N-1:0] WD3,
  output logic         pc_we,
  output logic [N-1:0] pc_wdata,
  output logic         busy,
  output logic         done
);

  state_t       state_q, state_d;
  logic [15:0]  list_q, list_d;   // original list, used to suppress writeback
  logic [15:0]  rem_q, rem_d;     // registers still to be loaded
  logic [N-1:0] addr_q, addr_d;   // running read address
  logic [3:0]   rn_q, rn_d;
  logic         wback_q, wback_d;
  logic [3:0]   cur_q, cur_d;     // register targeted by the outstanding read

  logic [3:0]   enc_idx;
  logic         enc_valid;
  logic [15:0]  rem_next;

  prio_enc16 u_prio_enc16 (
    .vec   (rem_q),
    .idx   (enc_idx),
    .valid (enc_valid)
  );

  always_comb begin
    state_d  = state_q;
    list_d   = list_q;
    rem_d    = rem_q;
    addr_d   = addr_q;
    rn_d     = rn_q;
    wback_d  = wback_q;
    cur_d    = cur_q;
    rem_next = rem_q & ~(16'd1 << cur_q);

    mem_re   = 1'b0;
    mem_addr = '0;
    WE3      = 1'b0;
    A3       = '0;
    WD3      = '0;
    pc_we    = 1'b0;
    pc_wdata = '0;

    case (state_q)
      StIdle: begin
        if (start) begin
          list_d  = reg_list;
          rem_d   = reg_list;
          addr_d  = base_addr;
          rn_d    = rn;
          wback_d = wback;
          if (reg_list != 16'd0) begin
            state_d = StReq;
          end else if (wback) begin
            state_d = StWb;
          end else begin
            state_d = StDone;
          end
        end
      end

      StReq: begin
        if (enc_valid) begin
          mem_re   = 1'b1;
          mem_addr = addr_q;
          cur_d    = enc_idx;
          state_d  = StWait;
        end else begin
          // Unreachable while rem_q is only entered non-empty; finish cleanly if it ever is.
          state_d = StDone;
        end
      end

      StWait: begin
        if (mem_rvalid) begin
          if (cur_q == RegPc) begin
            pc_we    = 1'b1;
            pc_wdata = mem_rdata;
          end else begin
            WE3 = 1'b1;
            A3  = cur_q;
            WD3 = mem_rdata;
          end
          rem_d  = rem_next;
          addr_d = addr_q + N'(ADDR_STEP);
          if (rem_next != 16'd0) begin
            state_d = StReq;
          end else if (wback_q && !list_q[rn_q]) begin
            // A loaded base register keeps the loaded value.
            state_d = StWb;
          end else begin
            state_d = StDone;
          end
        end
      end

      StWb: begin
        if (rn_q == RegPc) begin
          pc_we    = 1'b1;
          pc_wdata = addr_q;
        end else begin
          WE3 = 1'b1;
          A3  = rn_q;
          WD3 = addr_q;
        end
        state_d = StDone;
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign busy = (state_q != StIdle);
  assign done = (state_q == StDone);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      list_q  <= '0;
      rem_q   <= '0;
      addr_q  <= '0;
      rn_q    <= '0;
      wback_q <= 1'b0;
      cur_q   <= '0;
    end else begin
      state_q <= state_d;
      list_q  <= list_d;
      rem_q   <= rem_d;
      addr_q  <= addr_d;
      rn_q    <= rn_d;
      wback_q <= wback_d;
      cur_q   <= cur_d;
    end
  end

endmodule

// File: tb/tb_regfile_ldm_sequencer.sv
// Self-checking bench for regfile_ldm_sequencer. Expected read addresses and register/PC
// writes are queued when a command is issued and checked as the DUT produces them; a small
// memory responder returns data a programmable number of cycles after each read request.
module tb_regfile_ldm_sequencer;

  localparam int unsigned N = 32;

  typedef struct packed {
    logic         pc;
    logic [3:0]   idx;
    logic [N-1:0] data;
  } wr_t;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [15:0]  reg_list = '0;
  logic [N-1:0] base_addr = '0;
  logic         wback = 1'b0;
  logic [3:0]   rn = '0;
  logic         mem_re;
  logic [N-1:0] mem_addr;
  logic [N-1:0] mem_rdata = '0;
  logic         mem_rvalid = 1'b0;
  logic         WE3;
  logic [3:0]   A3;
  logic [N-1:0] WD3;
  logic         pc_we;
  logic [N-1:0] pc_wdata;
  logic         busy;
  logic         done;

  int n_checks = 0;
  int n_fail = 0;

  logic [N-1:0] exp_addr_q[$];
  wr_t          exp_wr_q[$];

  int           lat = 1;
  logic         pend = 1'b0;
  int           pend_cnt = 0;
  logic [N-1:0] pend_addr = '0;

  regfile_ldm_sequencer #(
    .N         (N),
    .ADDR_STEP (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .reg_list   (reg_list),
    .base_addr  (base_addr),
    .wback      (wback),
    .rn         (rn),
    .mem_re     (mem_re),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .mem_rvalid (mem_rvalid),
    .WE3        (WE3),
    .A3         (A3),
    .WD3        (WD3),
    .pc_we      (pc_we),
    .pc_wdata   (pc_wdata),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  function automatic logic [N-1:0] mem_val(input logic [N-1:0] a);
    return (a * 32'd7) ^ 32'hC0DE_1234;
  endfunction

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Monitor: checks requests and writes against the scoreboard queues.
  always @(negedge clk) begin
    wr_t got;
    if (mem_re) begin
      if (exp_addr_q.size() == 0) begin
        check_val("unexpected_mem_re", 64'(mem_addr), 64'hDEAD);
      end else begin
        check_val("mem_addr", 64'(mem_addr), 64'(exp_addr_q.pop_front()));
      end
      check_val("one_outstanding", 64'(pend), 64'd0);
      pend      = 1'b1;
      pend_cnt  = lat;
      pend_addr = mem_addr;
    end
    if (WE3 || pc_we) begin
      check_val("we_exclusive", 64'(WE3 && pc_we), 64'd0);
      got = pc_we ? {1'b1, 4'hF, pc_wdata} : {1'b0, A3, WD3};
      if (exp_wr_q.size() == 0) begin
        check_val("unexpected_write", 64'(got), 64'd0);
      end else begin
        check_val("reg_write", 64'(got), 64'(exp_wr_q.pop_front()));
      end
    end
  end

  // Memory responder: returns data lat cycles after the request cycle.
  always @(posedge clk) begin
    #1;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    if (pend) begin
      pend_cnt--;
      if (pend_cnt <= 0) begin
        mem_rvalid = 1'b1;
        mem_rdata  = mem_val(pend_addr);
        pend       = 1'b0;
      end
    end
  end

  task automatic check_idle_outputs(input string tag);
    check_val({tag, "_ctrl"}, 64'({mem_re, WE3, pc_we, busy, done, A3}), 64'd0);
    check_val({tag, "_mem_addr"}, 64'(mem_addr), 64'd0);
    check_val({tag, "_wd3"}, 64'(WD3), 64'd0);
    check_val({tag, "_pc_wdata"}, 64'(pc_wdata), 64'd0);
  endtask

  // Issues one command, fills the scoreboard and checks busy/done timing.
  // Cycle numbering counts the cycle in which start is presented as cycle 1.
  task automatic run_load(input string tag, input logic [15:0] list, input logic [N-1:0] base,
                          input logic wb, input logic [3:0] rn_v, input int l, input logic hold);
    logic [N-1:0] a;
    int           words;
    int           exp_done;
    int           cyc;
    int           seen_cyc;
    logic         do_wb;
    words    = 0;
    seen_cyc = 0;
    lat      = l;
    a        = base;
    for (int i = 0; i < 16; i++) begin
      if (list[i]) begin
        exp_addr_q.push_back(a);
        exp_wr_q.push_back({(i == 15), 4'(i), mem_val(a)});
        a = a + 32'd4;
        words++;
      end
    end
    do_wb = wb && !list[rn_v];
    if (do_wb) exp_wr_q.push_back({(rn_v == 4'hF), rn_v, a});
    exp_done = 2 + words * (1 + l) + (do_wb ? 1 : 0);

    @(posedge clk);
    #1;
    reg_list  = list;
    base_addr = base;
    wback     = wb;
    rn        = rn_v;
    start     = 1'b1;
    for (cyc = 1; cyc <= 300; cyc++) begin
      @(negedge clk);
      check_val({tag, "_busy"}, 64'(busy), 64'(cyc > 1));
      if (done) begin
        seen_cyc = cyc;
        break;
      end
      @(posedge clk);
      #1;
      if (!hold) start = 1'b0;
      // Scrambled command inputs must not disturb the captured command.
      reg_list  = 16'hFFFF;
      base_addr = 32'hBAD0_0000;
      wback     = ~wb;
      rn        = ~rn_v;
    end
    check_val({tag, "_done_cycle"}, 64'(seen_cyc), 64'(exp_done));
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    check_val({tag, "_back_idle"}, 64'({busy, done}), 64'd0);
    check_val({tag, "_reads_left"}, 64'(exp_addr_q.size()), 64'd0);
    check_val({tag, "_writes_left"}, 64'(exp_wr_q.size()), 64'd0);
    exp_addr_q.delete();
    exp_wr_q.delete();
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset");
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check_idle_outputs("post_reset");

    run_load("two_regs", 16'h0006, 32'h0000_0100, 1'b0, 4'd0, 1, 1'b0);
    run_load("r0_pc", 16'h8001, 32'h0000_0200, 1'b0, 4'd0, 1, 1'b0);
    run_load("wback", 16'h0030, 32'h0000_0040, 1'b1, 4'd2, 1, 1'b0);
    run_load("rn_in_list", 16'h0034, 32'h0000_0040, 1'b1, 4'd2, 1, 1'b0);
    run_load("empty_hold", 16'h0000, 32'h0000_0500, 1'b0, 4'd0, 1, 1'b1);
    run_load("empty_wb_pc", 16'h0000, 32'h0000_0080, 1'b1, 4'd15, 1, 1'b0);
    run_load("wrap_slow", 16'h0003, 32'hFFFF_FFFC, 1'b0, 4'd0, 3, 1'b1);

    // Reset while waiting for read data; the response arrives after reset release.
    lat = 3;
    exp_addr_q.push_back(32'h0000_0300);
    @(posedge clk);
    #1;
    reg_list  = 16'h0003;
    base_addr = 32'h0000_0300;
    wback     = 1'b1;
    rn        = 4'd7;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_idle_outputs("mid_reset");
    @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("after_late_rvalid");
    check_val("rst_reads_left", 64'(exp_addr_q.size()), 64'd0);
    check_val("rst_pending", 64'(pend), 64'd0);

    run_load("after_reset", 16'h8421, 32'h0000_1000, 1'b1, 4'd3, 2, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
